// File: rtl/fsm16_trace_decoder.sv
// Passive transition checker for the 16-state dual-input controller.
// Define FSM16_TRACE_RESYNC_EN to resynchronise after an illegal sample.
module fsm16_trace_decoder #(
    parameter int CNT_W = 16,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             state_valid,
    input  logic [3:0]       state_in,
    output logic             dec_valid,
    output logic             dec_taken,
    output logic [3:0]       dec_mask,
    output logic             dec_err,
    output logic             err_sticky,
    output logic [CNT_W-1:0] trans_cnt,
    output logic [ERR_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        SYNC,
        TRACK,
        HALT
    } mon_state_e;

    mon_state_e       state_q, state_d;
    logic [3:0]       ref_q, ref_d;
    logic             dec_valid_q, dec_valid_d;
    logic             dec_taken_q, dec_taken_d;
    logic [3:0]       dec_mask_q, dec_mask_d;
    logic             dec_err_q, dec_err_d;
    logic             err_sticky_q, err_sticky_d;
    logic [CNT_W-1:0] trans_cnt_q, trans_cnt_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    logic [2:0] j;
    logic [2:0] j_inc;
    logic [3:0] tgt_taken;
    logic [3:0] tgt_not;
    logic [3:0] mask_taken;
    logic       hit_taken;
    logic       hit_not;
    logic       illegal;

    always_comb begin
        j         = ref_q[2:0];
        j_inc     = j + 3'd1;
        tgt_taken = {j, 1'b1};
        tgt_not   = {j_inc, 1'b0};
        hit_taken = (state_in == tgt_taken);
        hit_not   = (state_in == tgt_not);
        // not-taken mask is always the complement of the taken mask
        unique case (j)
            3'd0:    mask_taken = 4'b1000;
            3'd1:    mask_taken = 4'b0010;
            3'd2:    mask_taken = 4'b0100;
            3'd3:    mask_taken = 4'b0001;
            3'd4:    mask_taken = 4'b1110;
            3'd5:    mask_taken = 4'b1011;
            3'd6:    mask_taken = 4'b1101;
            default: mask_taken = 4'b0111;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        ref_d        = ref_q;
        dec_valid_d  = 1'b0;
        dec_taken_d  = 1'b0;
        dec_mask_d   = 4'b0000;
        dec_err_d    = 1'b0;
        err_sticky_d = err_sticky_q;
        trans_cnt_d  = trans_cnt_q;
        err_cnt_d    = err_cnt_q;
        illegal      = 1'b0;

        if (state_valid) begin
            dec_valid_d = 1'b1;
            unique case (state_q)
                SYNC: begin
                    if (state_in == 4'd0) begin
                        state_d = TRACK;
                        ref_d   = 4'd0;
                    end else begin
                        illegal = 1'b1;
                    end
                end
                TRACK: begin
                    unique case (1'b1)
                        hit_taken: begin
                            dec_taken_d = 1'b1;
                            dec_mask_d  = mask_taken;
                            ref_d       = state_in;
                        end
                        hit_not: begin
                            dec_mask_d = ~mask_taken;
                            ref_d      = state_in;
                        end
                        default: illegal = 1'b1;
                    endcase
                    if (!illegal && trans_cnt_q != '1)
                        trans_cnt_d = trans_cnt_q + CNT_W'(1);
                end
                default: ;
            endcase

            if (illegal) begin
                dec_err_d    = 1'b1;
                err_sticky_d = 1'b1;
                if (err_cnt_q != '1)
                    err_cnt_d = err_cnt_q + ERR_W'(1);
`ifdef FSM16_TRACE_RESYNC_EN
                ref_d   = state_in;
                state_d = TRACK;
`else
                state_d = HALT;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= SYNC;
            ref_q        <= 4'd0;
            dec_valid_q  <= 1'b0;
            dec_taken_q  <= 1'b0;
            dec_mask_q   <= 4'b0000;
            dec_err_q    <= 1'b0;
            err_sticky_q <= 1'b0;
            trans_cnt_q  <= '0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            ref_q        <= ref_d;
            dec_valid_q  <= dec_valid_d;
            dec_taken_q  <= dec_taken_d;
            dec_mask_q   <= dec_mask_d;
            dec_err_q    <= dec_err_d;
            err_sticky_q <= err_sticky_d;
            trans_cnt_q  <= trans_cnt_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign dec_valid  = dec_valid_q;
    assign dec_taken  = dec_taken_q;
    assign dec_mask   = dec_mask_q;
    assign dec_err    = dec_err_q;
    assign err_sticky = err_sticky_q;
    assign trans_cnt  = trans_cnt_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_fsm16_trace_decoder.sv
// Bench for fsm16_trace_decoder: directed plan plus random streams
// checked against a rule-level reference model.
module tb_fsm16_trace_decoder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        state_valid = 1'b0;
    logic [3:0]  state_in = 4'd0;

    logic        dec_valid, dec_taken, dec_err, err_sticky;
    logic [3:0]  dec_mask;
    logic [15:0] trans_cnt;
    logic [7:0]  err_cnt;

    logic        dec_valid4, dec_taken4, dec_err4, err_sticky4;
    logic [3:0]  dec_mask4;
    logic [3:0]  trans_cnt4;
    logic [7:0]  err_cnt4;

    int total = 0;
    int bad = 0;

    localparam int M_SYNC = 0;
    localparam int M_TRACK = 1;
    localparam int M_HALT = 2;

    int m_mode, m_ref, m_tc, m_ec;
    bit m_st;
    bit e_v, e_t, e_e;
    int e_m;

    always #5 clk = ~clk;

    fsm16_trace_decoder u_dut (
        .clk(clk), .reset(reset),
        .state_valid(state_valid), .state_in(state_in),
        .dec_valid(dec_valid), .dec_taken(dec_taken),
        .dec_mask(dec_mask), .dec_err(dec_err),
        .err_sticky(err_sticky), .trans_cnt(trans_cnt),
        .err_cnt(err_cnt)
    );

    fsm16_trace_decoder #(.CNT_W(4)) u_dut4 (
        .clk(clk), .reset(reset),
        .state_valid(state_valid), .state_in(state_in),
        .dec_valid(dec_valid4), .dec_taken(dec_taken4),
        .dec_mask(dec_mask4), .dec_err(dec_err4),
        .err_sticky(err_sticky4), .trans_cnt(trans_cnt4),
        .err_cnt(err_cnt4)
    );

    function automatic bit cond(int j, bit a, bit b);
        case (j)
            0: return a && b;
            1: return !a && b;
            2: return a && !b;
            3: return !a && !b;
            4: return a || b;
            5: return !a || b;
            6: return a || !b;
            default: return !a || !b;
        endcase
    endfunction

    function automatic int mask_of(int j, bit tk);
        int m = 0;
        for (int c = 0; c < 4; c++)
            if (cond(j, bit'(c / 2), bit'(c % 2)) == tk)
                m |= (1 << c);
        return m;
    endfunction

    function automatic int sat(int v, int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic bad_sample(int s);
        e_e = 1;
        m_st = 1;
        m_ec++;
`ifdef FSM16_TRACE_RESYNC_EN
        m_ref = s;
        m_mode = M_TRACK;
`else
        m_mode = M_HALT;
`endif
    endtask

    task automatic model(bit rst_n, bit v, int s);
        int j;
        e_v = 0; e_t = 0; e_e = 0; e_m = 0;
        if (!rst_n) begin
            m_mode = M_SYNC; m_ref = 0;
            m_tc = 0; m_ec = 0; m_st = 0;
            return;
        end
        if (!v) return;
        e_v = 1;
        if (m_mode == M_HALT) return;
        if (m_mode == M_SYNC) begin
            if (s == 0) begin
                m_mode = M_TRACK;
                m_ref = 0;
            end else begin
                bad_sample(s);
            end
            return;
        end
        j = m_ref % 8;
        if (s == 2 * j + 1) begin
            e_t = 1;
            e_m = mask_of(j, 1);
            m_tc++;
            m_ref = s;
        end else if (s == (2 * j + 2) % 16) begin
            e_m = mask_of(j, 0);
            m_tc++;
            m_ref = s;
        end else begin
            bad_sample(s);
        end
    endtask

    task automatic chk(string tag, int obs, int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(bit rst_n, bit v, int s);
        @(negedge clk);
        reset = rst_n;
        state_valid = v;
        state_in = 4'(s);
        @(posedge clk);
        #1;
        model(rst_n, v, s);
        chk("valid", int'(dec_valid), int'(e_v));
        chk("sticky", int'(err_sticky), int'(m_st));
        chk("tcnt", int'(trans_cnt), sat(m_tc, 65535));
        chk("ecnt", int'(err_cnt), sat(m_ec, 255));
        chk("tcnt4", int'(trans_cnt4), sat(m_tc, 15));
        chk("ecnt4", int'(err_cnt4), sat(m_ec, 255));
        if (e_v || !rst_n) begin
            chk("taken", int'(dec_taken), int'(e_t));
            chk("mask", int'(dec_mask), e_m);
            chk("err", int'(dec_err), int'(e_e));
        end
    endtask

    task automatic seq(int n, int q[16]);
        for (int i = 0; i < n; i++) step(1, 1, q[i]);
    endtask

    task automatic next_legal(output int s);
        int j = m_ref % 8;
        if (m_mode != M_TRACK) s = 0;
        else if ($urandom_range(0, 1) == 1) s = 2 * j + 1;
        else s = (2 * j + 2) % 16;
    endtask

    initial begin
        int s;
        int r;
        model(0, 0, 0);
        step(0, 0, 0);
        step(0, 1, 5);

        // plan 1: S0,S1,S3,S7,S15,S0
        seq(6, '{0, 1, 3, 7, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        chk("p1_tc", int'(trans_cnt), 5);
        chk("p1_ec", int'(err_cnt), 0);

        // plan 2: S11->S7 legal, S11->S6 illegal
        step(0, 0, 0);
        seq(5, '{0, 2, 5, 11, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        chk("p2_mask", int'(dec_mask), 4'b0001);
        step(0, 0, 0);
        seq(5, '{0, 2, 5, 11, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        chk("p2_err", int'(dec_err), 1);
        chk("p2_ec", int'(err_cnt), 1);

        // plan 3: bad first sample, then S9
        step(0, 0, 0);
        seq(2, '{4, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        step(1, 1, 3);

        // plan 4: S14 self-loop
        step(0, 0, 0);
        seq(6, '{0, 2, 6, 14, 14, 14, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        chk("p4_mask", int'(dec_mask), 4'b0010);

        // plan 5: gaps and reset colliding with a sample
        step(0, 0, 0);
        step(1, 1, 0);
        repeat (3) step(1, 0, 1);
        step(1, 1, 1);
        repeat (3) step(1, 0, 3);
        step(1, 1, 3);
        step(0, 1, 7);
        step(1, 1, 7);

        // plan 6: counter saturation on the narrow instance
        step(0, 0, 0);
        step(1, 1, 0);
        repeat (20) begin
            next_legal(s);
            step(1, 1, s);
        end
        chk("p6_tc4", int'(trans_cnt4), 15);

        // random traffic
        step(0, 0, 0);
        repeat (1500) begin
            r = $urandom_range(0, 99);
            if (r < 2) step(0, $urandom_range(0, 1), 0);
            else if (r < 15) step(1, 0, $urandom_range(0, 15));
            else if (r < 22) step(1, 1, $urandom_range(0, 15));
            else begin
                next_legal(s);
                step(1, 1, s);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
